// File: rtl/ws_tile_sched_if.sv
// ws_tile_sched_if: bundle of every non-clock signal of the layer tile scheduler.
//   Host side:       start, abort, layer configuration (tile counts, bases, strides),
//                    busy / done / err / aborted status.
//   Controller side: ctrl_go / ctrl_done handshake plus the per-pass tile
//                    descriptor (buffer base addresses, tile indices, reload flag).
// Modports:
//   master - the scheduler itself (drives go, descriptor and status)
//   slave  - the environment (host + array controller)
interface ws_tile_sched_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
);
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_wtiles;
  logic [CNT_W-1:0]  num_itiles;
  logic [ADDR_W-1:0] weight_base;
  logic [ADDR_W-1:0] iact_base;
  logic [ADDR_W-1:0] psum_base;
  logic [ADDR_W-1:0] iact_stride;
  logic [ADDR_W-1:0] psum_stride;
  logic              ctrl_go;
  logic              ctrl_done;
  logic              reload_weights;
  logic [ADDR_W-1:0] tile_weight_addr;
  logic [ADDR_W-1:0] tile_iact_addr;
  logic [ADDR_W-1:0] tile_psum_addr;
  logic [CNT_W-1:0]  w_idx;
  logic [CNT_W-1:0]  i_idx;
  logic              busy;
  logic              done;
  logic              err;
  logic              aborted;

  modport master (
    input  start, abort, num_wtiles, num_itiles, weight_base, iact_base,
           psum_base, iact_stride, psum_stride, ctrl_done,
    output ctrl_go, reload_weights, tile_weight_addr, tile_iact_addr,
           tile_psum_addr, w_idx, i_idx, busy, done, err, aborted
  );

  modport slave (
    output start, abort, num_wtiles, num_itiles, weight_base, iact_base,
           psum_base, iact_stride, psum_stride, ctrl_done,
    input  ctrl_go, reload_weights, tile_weight_addr, tile_iact_addr,
           tile_psum_addr, w_idx, i_idx, busy, done, err, aborted
  );
endinterface

// File: rtl/ws_tile_sched.sv
// ws_tile_sched: layer-level scheduler above the PE-array controller.
// Splits a layer into num_wtiles x num_itiles passes (weight tile outer loop,
// iact tile inner loop), issues one ctrl_go per pass, waits for ctrl_done and
// presents the buffer base addresses for each pass. The host sees a single
// start / busy / done transaction per layer.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - ws_tile_sched_if.master (host config/status + controller handshake)
// All outputs are registered; address arithmetic wraps modulo 2^ADDR_W.
module ws_tile_sched #(
  parameter int ADDR_W      = 10,
  parameter int CNT_W       = 8,
  parameter int ARRAY_DIM   = 3,
  parameter int WTILE_WORDS = ARRAY_DIM * ARRAY_DIM
) (
  input  logic             clk,
  input  logic             rst,
  ws_tile_sched_if.master  bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADVANCE, DRAIN, FIN} state_t;

  localparam logic [ADDR_W-1:0] WTILE_STEP = ADDR_W'(WTILE_WORDS);
  localparam logic [CNT_W:0]    CNT_ONE    = (CNT_W+1)'(1);

  state_t            state;
  logic              err_pend;
  logic [CNT_W-1:0]  nwt;
  logic [CNT_W-1:0]  nit;
  logic [ADDR_W-1:0] iact_base_r;
  logic [ADDR_W-1:0] iact_stride_r;
  logic [ADDR_W-1:0] psum_stride_r;

  logic              go;
  logic              rl;
  logic [ADDR_W-1:0] wa;
  logic [ADDR_W-1:0] ia;
  logic [ADDR_W-1:0] pa;
  logic [CNT_W-1:0]  wi;
  logic [CNT_W-1:0]  ii;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              ab_r;

  // One extra bit so index+1 never overflows when a count is 2^CNT_W-1.
  logic [CNT_W:0] i_inc;
  logic [CNT_W:0] w_inc;
  logic           i_wrap;
  logic           w_last;
  logic           zero_cfg;

  assign i_inc    = {1'b0, ii} + CNT_ONE;
  assign w_inc    = {1'b0, wi} + CNT_ONE;
  assign i_wrap   = (i_inc >= {1'b0, nit});
  assign w_last   = (w_inc == {1'b0, nwt});
  assign zero_cfg = (bus.num_wtiles == '0) || (bus.num_itiles == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      err_pend      <= 1'b0;
      nwt           <= '0;
      nit           <= '0;
      iact_base_r   <= '0;
      iact_stride_r <= '0;
      psum_stride_r <= '0;
      go            <= 1'b0;
      rl            <= 1'b0;
      wa            <= '0;
      ia            <= '0;
      pa            <= '0;
      wi            <= '0;
      ii            <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      ab_r          <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised only on the transition that owns it.
      go     <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      ab_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            nwt           <= bus.num_wtiles;
            nit           <= bus.num_itiles;
            iact_base_r   <= bus.iact_base;
            iact_stride_r <= bus.iact_stride;
            psum_stride_r <= bus.psum_stride;
            wi            <= '0;
            ii            <= '0;
            wa            <= bus.weight_base;
            ia            <= bus.iact_base;
            pa            <= bus.psum_base;
            busy_r        <= 1'b1;
            rl            <= ~zero_cfg;
            // A zero-sized layer still passes through ISSUE (without a go) so
            // busy is seen for one cycle before the error completion.
            err_pend      <= zero_cfg;
            go            <= ~zero_cfg;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (err_pend) begin
            done_r <= 1'b1;
            err_r  <= 1'b1;
            busy_r <= 1'b0;
            state  <= FIN;
          end else if (bus.abort) begin
            done_r <= 1'b1;
            ab_r   <= 1'b1;
            busy_r <= 1'b0;
            state  <= FIN;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.ctrl_done) begin
            if (bus.abort) begin
              done_r <= 1'b1;
              ab_r   <= 1'b1;
              busy_r <= 1'b0;
              state  <= FIN;
            end else begin
              state <= ADVANCE;
            end
          end else if (bus.abort) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The controller is mid-pass; let it finish before reporting.
          if (bus.ctrl_done) begin
            done_r <= 1'b1;
            ab_r   <= 1'b1;
            busy_r <= 1'b0;
            state  <= FIN;
          end
        end
        ADVANCE: begin
          if (bus.abort) begin
            done_r <= 1'b1;
            ab_r   <= 1'b1;
            busy_r <= 1'b0;
            state  <= FIN;
          end else begin
            pa <= pa + psum_stride_r;
            if (!i_wrap) begin
              ii    <= i_inc[CNT_W-1:0];
              ia    <= ia + iact_stride_r;
              rl    <= 1'b0;
              go    <= 1'b1;
              state <= ISSUE;
            end else begin
              ii <= '0;
              ia <= iact_base_r;
              rl <= 1'b1;
              if (w_last) begin
                // w_idx stays on the last weight tile.
                done_r <= 1'b1;
                busy_r <= 1'b0;
                state  <= FIN;
              end else begin
                wi    <= w_inc[CNT_W-1:0];
                wa    <= wa + WTILE_STEP;
                go    <= 1'b1;
                state <= ISSUE;
              end
            end
          end
        end
        FIN: begin
          // done/err/aborted are visible during this cycle; start is not honoured here.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ctrl_go          = go;
  assign bus.reload_weights   = rl;
  assign bus.tile_weight_addr = wa;
  assign bus.tile_iact_addr   = ia;
  assign bus.tile_psum_addr   = pa;
  assign bus.w_idx            = wi;
  assign bus.i_idx            = ii;
  assign bus.busy             = busy_r;
  assign bus.done             = done_r;
  assign bus.err              = err_r;
  assign bus.aborted          = ab_r;

endmodule

// File: tb/tb_ws_tile_sched.sv
// tb_ws_tile_sched: scoreboard bench for ws_tile_sched. Stimulus pushes the
// expected per-pass descriptor and layer completion into queues; a monitor
// pops and compares whenever ctrl_go or done is presented. A small controller
// model answers each ctrl_go with ctrl_done after ctrl_lat cycles.
module tb_ws_tile_sched;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ws_tile_sched_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

  ws_tile_sched #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .ARRAY_DIM(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int w; int i; int wa; int ia; int pa; int rl; } go_exp_t;
  typedef struct { int err; int ab; } done_exp_t;

  go_exp_t   go_q[$];
  done_exp_t done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int go_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int busy_cyc = 0;
  int cdone_edge = -1;
  int last_go_cyc = -1;
  int ctrl_lat = 5;
  int start_edge = 0;
  bit gap_en = 1'b0;
  logic model_done = 1'b0;
  logic stray_done = 1'b0;

  assign bus.ctrl_done = model_done | stray_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Controller model.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.ctrl_go === 1'b1) begin
        repeat (ctrl_lat) @(negedge clk);
        model_done = 1'b1;
        cdone_edge = cyc + 1;
        @(negedge clk);
        model_done = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    go_exp_t   ge;
    done_exp_t de;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.ctrl_go === 1'b1) begin
        go_cnt++;
        if (gap_en && cdone_edge > last_go_cyc && last_go_cyc >= 0)
          chk("go_after_done", cyc, cdone_edge + 1);
        last_go_cyc = cyc;
        if (go_q.size() == 0) begin
          chk("go_unexpected", 1, 0);
        end else begin
          ge = go_q.pop_front();
          chk("w_idx", int'(bus.w_idx), ge.w);
          chk("i_idx", int'(bus.i_idx), ge.i);
          chk("weight_addr", int'(bus.tile_weight_addr), ge.wa);
          chk("iact_addr", int'(bus.tile_iact_addr), ge.ia);
          chk("psum_addr", int'(bus.tile_psum_addr), ge.pa);
          chk("reload", int'(bus.reload_weights), ge.rl);
        end
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        if (done_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          de = done_q.pop_front();
          chk("err", int'(bus.err), de.err);
          chk("aborted", int'(bus.aborted), de.ab);
          chk("busy_at_done", int'(bus.busy), 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic push_go(input int w, input int i, input int wa, input int ia,
                         input int pa, input int rl);
    go_exp_t e;
    e.w = w; e.i = i; e.wa = wa; e.ia = ia; e.pa = pa; e.rl = rl;
    go_q.push_back(e);
  endtask

  task automatic push_done(input int err, input int ab);
    done_exp_t e;
    e.err = err; e.ab = ab;
    done_q.push_back(e);
  endtask

  // Nominal 2x3 grid: bases 0/100/200, iact_stride 9, psum_stride 3.
  task automatic push_nominal(input int passes, input bit with_done);
    int nw[6] = '{0, 0, 0, 1, 1, 1};
    int ni[6] = '{0, 1, 2, 0, 1, 2};
    int nwa[6] = '{0, 0, 0, 9, 9, 9};
    int nia[6] = '{100, 109, 118, 100, 109, 118};
    int npa[6] = '{200, 203, 206, 209, 212, 215};
    int nrl[6] = '{1, 0, 0, 1, 0, 0};
    for (int k = 0; k < passes; k++) push_go(nw[k], ni[k], nwa[k], nia[k], npa[k], nrl[k]);
    if (with_done) push_done(0, 0);
  endtask

  // Drives a start for one cycle; returns at the negedge of the cycle after
  // the accepting edge (the cycle in which ctrl_go is expected).
  task automatic start_layer(input int nw, input int ni, input int wb, input int ib,
                             input int pb, input int is, input int ps);
    @(negedge clk);
    bus.num_wtiles  = CNT_W'(nw);
    bus.num_itiles  = CNT_W'(ni);
    bus.weight_base = ADDR_W'(wb);
    bus.iact_base   = ADDR_W'(ib);
    bus.psum_base   = ADDR_W'(pb);
    bus.iact_stride = ADDR_W'(is);
    bus.psum_stride = ADDR_W'(ps);
    bus.start       = 1'b1;
    start_edge      = cyc + 1;
    @(negedge clk);
    bus.start       = 1'b0;
    // Scramble config so only the latched values can be in use.
    bus.num_wtiles  = CNT_W'(1);
    bus.num_itiles  = CNT_W'(7);
    bus.weight_base = ADDR_W'(555);
    bus.iact_base   = ADDR_W'(444);
    bus.psum_base   = ADDR_W'(333);
    bus.iact_stride = ADDR_W'(77);
    bus.psum_stride = ADDR_W'(66);
  endtask

  task automatic wait_done(input int target, input int bound);
    int n = 0;
    while (done_cnt < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", int'(done_cnt >= target), 1);
  endtask

  // Counts further ctrl_go pulses until the total seen by this call reaches target.
  task automatic wait_gos(input int already, input int target, input int bound);
    int c = already;
    int n = 0;
    while (c < target && n < bound) begin
      @(negedge clk);
      n++;
      if (bus.ctrl_go === 1'b1) c++;
    end
    chk("go_wait", int'(c >= target), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl_go"}, int'(bus.ctrl_go), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
    chk({tag, "_aborted"}, int'(bus.aborted), 0);
    chk({tag, "_reload"}, int'(bus.reload_weights), 0);
    chk({tag, "_waddr"}, int'(bus.tile_weight_addr), 0);
    chk({tag, "_iaddr"}, int'(bus.tile_iact_addr), 0);
    chk({tag, "_paddr"}, int'(bus.tile_psum_addr), 0);
    chk({tag, "_w_idx"}, int'(bus.w_idx), 0);
    chk({tag, "_i_idx"}, int'(bus.i_idx), 0);
  endtask

  initial begin
    int g0;
    int d0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.num_wtiles = '0;
    bus.num_itiles = '0;
    bus.weight_base = '0;
    bus.iact_base = '0;
    bus.psum_base = '0;
    bus.iact_stride = '0;
    bus.psum_stride = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal grid.
    g0 = go_cnt; d0 = done_cnt;
    push_nominal(6, 1'b1);
    gap_en = 1'b1;
    start_layer(2, 3, 0, 100, 200, 9, 3);
    chk("nom_go_latency", int'(bus.ctrl_go), 1);
    wait_done(d0 + 1, 300);
    chk("nom_done_latency", done_cyc, cdone_edge + 1);
    gap_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("nom_go_count", go_cnt - g0, 6);
    chk("nom_done_count", done_cnt - d0, 1);

    // Zero configuration.
    g0 = go_cnt; d0 = done_cnt;
    push_done(1, 0);
    busy_cyc = 0;
    start_layer(3, 0, 0, 100, 200, 9, 3);
    wait_done(d0 + 1, 20);
    chk("zero_done_latency", done_cyc, start_edge + 1);
    repeat (3) @(negedge clk);
    chk("zero_busy_cycles", busy_cyc, 1);
    chk("zero_go_count", go_cnt - g0, 0);

    // Abort during WAIT of pass 2, controller slow.
    ctrl_lat = 10;
    g0 = go_cnt; d0 = done_cnt;
    push_nominal(2, 1'b0);
    push_done(0, 1);
    start_layer(2, 3, 0, 100, 200, 9, 3);
    wait_gos(1, 2, 50);
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    wait_done(d0 + 1, 50);
    chk("abort_done_latency", done_cyc, cdone_edge);
    repeat (15) @(negedge clk);
    chk("abort_go_count", go_cnt - g0, 2);
    ctrl_lat = 5;

    // Address wrap modulo 2^10.
    g0 = go_cnt; d0 = done_cnt;
    push_go(0, 0, 1020, 1000, 1020, 1);
    push_go(0, 1, 1020, 6, 1, 0);
    push_go(0, 2, 1020, 36, 6, 0);
    push_done(0, 0);
    start_layer(1, 3, 1020, 1000, 1020, 30, 5);
    wait_done(d0 + 1, 100);
    repeat (3) @(negedge clk);
    chk("wrap_go_count", go_cnt - g0, 3);

    // Protocol noise: stray done in IDLE, start while busy, stray done in ISSUE.
    g0 = go_cnt; d0 = done_cnt;
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    push_nominal(6, 1'b1);
    start_layer(2, 3, 0, 100, 200, 9, 3);
    @(negedge clk);
    bus.num_itiles = '0;
    bus.psum_base  = ADDR_W'(7);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_gos(1, 4, 60);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    wait_done(d0 + 1, 200);
    repeat (3) @(negedge clk);
    chk("noise_go_count", go_cnt - g0, 6);
    chk("noise_done_count", done_cnt - d0, 1);

    // Reset in WAIT of pass 3, then a clean full layer.
    d0 = done_cnt;
    push_nominal(3, 1'b0);
    start_layer(2, 3, 0, 100, 200, 9, 3);
    wait_gos(1, 3, 60);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    g0 = go_cnt; d0 = done_cnt;
    push_nominal(6, 1'b1);
    start_layer(2, 3, 0, 100, 200, 9, 3);
    chk("rerun_go_latency", int'(bus.ctrl_go), 1);
    wait_done(d0 + 1, 300);
    repeat (3) @(negedge clk);
    chk("rerun_go_count", go_cnt - g0, 6);

    chk("go_queue_empty", go_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
